// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 constants and seven-segment digit table
package sap1_pkg;

    localparam int DATA_W = 8;
    localparam int SEG_W  = 7;

    // All segments dark, expressed in active-high {g,f,e,d,c,b,a} form
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Active-high {g,f,e,d,c,b,a} pattern for a BCD digit; codes 10..15 stay dark
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] digit);
        logic [SEG_W-1:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// rtl/bin8_to_bcd.sv - combinational double-dabble conversion of a byte to three BCD digits
module bin8_to_bcd
    import sap1_pkg::*;
(
    input  logic [DATA_W-1:0] bin,
    output logic [3:0]        hund,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    // Working register: {hund, tens, ones, binary}; shifted left once per input bit
    logic [19:0] shift;

    // Add-3-then-shift on each BCD column before every shift
    always_comb begin
        shift = {12'd0, bin};
        for (int i = 0; i < DATA_W; i++) begin
            if (shift[11:8] >= 4'd5) begin
                shift[11:8] = shift[11:8] + 4'd3;
            end
            if (shift[15:12] >= 4'd5) begin
                shift[15:12] = shift[15:12] + 4'd3;
            end
            if (shift[19:16] >= 4'd5) begin
                shift[19:16] = shift[19:16] + 4'd3;
            end
            shift = shift << 1;
        end
    end

    assign hund = shift[19:16];
    assign tens = shift[15:12];
    assign ones = shift[11:8];

endmodule

// File: rtl/output_register.sv
// rtl/output_register.sv - SAP-1 output register with decimal seven-segment readout
module output_register
    import sap1_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] w_bus,
    output logic [DATA_W-1:0] o,
    output logic              o_valid,
    output logic [SEG_W-1:0]  seg_hund,
    output logic [SEG_W-1:0]  seg_tens,
    output logic [SEG_W-1:0]  seg_ones
);

    // Common-anode displays light a segment by driving it low
    localparam logic [SEG_W-1:0] SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};

    logic [3:0] hund_digit;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;

    // Output latch: reload on every load edge, reset wins over load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o       <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            o       <= w_bus;
            o_valid <= 1'b1;
        end
    end

    bin8_to_bcd u_bcd (
        .bin  (o),
        .hund (hund_digit),
        .tens (tens_digit),
        .ones (ones_digit)
    );

    // Decode digits with leading-zero blanking, then apply display polarity
    always_comb begin
        seg_hund = SEG_BLANK;
        seg_tens = SEG_BLANK;
        seg_ones = seg_encode(ones_digit);
        if (hund_digit != 4'd0) begin
            seg_hund = seg_encode(hund_digit);
            seg_tens = seg_encode(tens_digit);
        end else if (tens_digit != 4'd0) begin
            seg_tens = seg_encode(tens_digit);
        end
        seg_hund = seg_hund ^ SEG_POL;
        seg_tens = seg_tens ^ SEG_POL;
        seg_ones = seg_ones ^ SEG_POL;
    end

endmodule

// File: tb/tb_output_register.sv
// tb/tb_output_register.sv - scoreboard bench for output_register
module tb_output_register;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] BL = 7'b0000000;

    typedef struct {
        string      name;
        logic [7:0] o;
        logic       valid;
        logic [6:0] hund;
        logic [6:0] tens;
        logic [6:0] ones;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] w_bus;

    logic [7:0] o_h, o_l;
    logic       v_h, v_l;
    logic [6:0] hund_h, tens_h, ones_h;
    logic [6:0] hund_l, tens_l, ones_l;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    output_register #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .w_bus    (w_bus),
        .o        (o_h),
        .o_valid  (v_h),
        .seg_hund (hund_h),
        .seg_tens (tens_h),
        .seg_ones (ones_h)
    );

    output_register #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .w_bus    (w_bus),
        .o        (o_l),
        .o_valid  (v_l),
        .seg_hund (hund_l),
        .seg_tens (tens_l),
        .seg_ones (ones_l)
    );

    task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: whenever an expectation is posted, compare both instances against it
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            cmp(e.name, "o",          o_h,             e.o);
            cmp(e.name, "o_valid",    {7'd0, v_h},     {7'd0, e.valid});
            cmp(e.name, "seg_hund",   {1'b0, hund_h},  {1'b0, e.hund});
            cmp(e.name, "seg_tens",   {1'b0, tens_h},  {1'b0, e.tens});
            cmp(e.name, "seg_ones",   {1'b0, ones_h},  {1'b0, e.ones});
            cmp(e.name, "al_o",       o_l,             e.o);
            cmp(e.name, "al_valid",   {7'd0, v_l},     {7'd0, e.valid});
            cmp(e.name, "al_seg_hund", {1'b0, hund_l}, {1'b0, ~e.hund});
            cmp(e.name, "al_seg_tens", {1'b0, tens_l}, {1'b0, ~e.tens});
            cmp(e.name, "al_seg_ones", {1'b0, ones_l}, {1'b0, ~e.ones});
        end
    end

    // Post an expectation and wait (bounded) for the monitor to consume it
    task automatic expect_now(input string name, input logic [7:0] o_exp, input logic v_exp,
                              input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        exp_t e;
        int   guard;
        e.name = name; e.o = o_exp; e.valid = v_exp; e.hund = h; e.tens = t; e.ones = u;
        exp_q.push_back(e);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s.monitor_timeout: queue depth %0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic load_edge(input logic [7:0] data);
        @(negedge clk);
        load  = 1'b1;
        w_bus = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        w_bus = 8'h00;
        #3;
        expect_now("reset_state", 8'h00, 1'b0, BL, BL, S0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_edge(8'h0F);
        expect_now("load_0f", 8'h0F, 1'b1, BL, S1, S5);

        @(negedge clk);
        load  = 1'b0;
        w_bus = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            expect_now($sformatf("hold_%0d", i), 8'h0F, 1'b1, BL, S1, S5);
        end

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_now("async_reset", 8'h00, 1'b0, BL, BL, S0);
        load_edge(8'h0F);
        expect_now("load_during_reset", 8'h00, 1'b0, BL, BL, S0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_now("post_reset_reload", 8'h0F, 1'b1, BL, S1, S5);

        load_edge(8'd18);
        expect_now("load_18", 8'd18, 1'b1, BL, S1, S8);
        load_edge(8'd52);
        expect_now("back_to_back_52", 8'd52, 1'b1, BL, S5, S2);
        load_edge(8'hFF);
        expect_now("load_255", 8'hFF, 1'b1, S2, S5, S5);
        load_edge(8'd100);
        expect_now("load_100", 8'd100, 1'b1, S1, S0, S0);
        load_edge(8'd10);
        expect_now("load_10", 8'd10, 1'b1, BL, S1, S0);
        load_edge(8'd9);
        expect_now("load_9", 8'd9, 1'b1, BL, BL, S9);
        load_edge(8'd8);
        expect_now("load_8", 8'd8, 1'b1, BL, BL, S8);
        load_edge(8'd0);
        expect_now("load_0", 8'd0, 1'b1, BL, BL, S0);

        @(negedge clk);
        load = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
